// File: rtl/kb_mmio_pkg.sv
// Shared constants and state encoding for the keyboard MMIO bridge.
package kb_mmio_pkg;

  localparam logic [63:0] KB_OFF_STATUS = 64'h00;
  localparam logic [63:0] KB_OFF_DATA   = 64'h08;
  localparam logic [63:0] KB_OFF_CTRL   = 64'h10;
  localparam logic [63:0] KB_WIN_BYTES  = 64'd24;

  localparam int ST_KB_STATUS = 0;
  localparam int ST_BUF_FULL  = 1;
  localparam int ST_FULL_SEEN = 2;
  localparam int ST_IRQ_EN    = 3;

  localparam int CTRL_CLEAR    = 0;
  localparam int CTRL_IRQ_EN   = 1;
  localparam int CTRL_FS_CLEAR = 2;

  localparam int KB_EMPTY_FLAG = 63;

  typedef enum logic [1:0] {S_IDLE, S_POP, S_WAIT, S_RESP} kb_state_e;

endpackage

// File: rtl/kb_mmio_port.sv
// CPU data-bus bridge to the keyboard buffer: STATUS/DATA/CONTROL registers,
// pop sequencing with a settle delay, and a level interrupt.
module kb_mmio_port
  import kb_mmio_pkg::*;
#(
  parameter logic [63:0] KB_BASE_ADDR = 64'h0000_0000_0000_F000,
  parameter int          POP_WAIT     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [63:0] mem_addr,
  input  logic [63:0] mem_wdata,
  output logic [63:0] mem_rdata,
  output logic        mem_ready,
  input  logic        KB_status,
  input  logic [6:0]  KB_data,
  input  logic        buf_full,
  output logic        KB_read_en,
  output logic        KB_clear,
  output logic        kb_irq
);

  kb_state_e   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] resp_q, resp_d;
  logic [63:0] rdata_q, rdata_d;
  logic        ready_q, ready_d;
  logic        read_en_q, read_en_d;
  logic        clear_q, clear_d;
  logic        irq_en_q, irq_en_d;
  logic        full_seen_q, full_seen_d;
  logic        irq_q, irq_d;

  logic [63:0] offset;
  logic        hit, is_status, is_data, is_ctrl, fs_clr;
  logic [63:0] status_val, ctrl_val, empty_val;

  assign offset    = mem_addr - KB_BASE_ADDR;
  assign hit       = mem_req && (mem_addr >= KB_BASE_ADDR)
                     && (mem_addr < KB_BASE_ADDR + KB_WIN_BYTES) && (mem_addr[2:0] == 3'b000);
  assign is_status = (offset == KB_OFF_STATUS);
  assign is_data   = (offset == KB_OFF_DATA);
  assign is_ctrl   = (offset == KB_OFF_CTRL);

  always_comb begin
    status_val = '0;
    status_val[ST_KB_STATUS] = KB_status;
    status_val[ST_BUF_FULL]  = buf_full;
    status_val[ST_FULL_SEEN] = full_seen_q;
    status_val[ST_IRQ_EN]    = irq_en_q;
    ctrl_val = '0;
    ctrl_val[CTRL_IRQ_EN] = irq_en_q;
    empty_val = '0;
    empty_val[KB_EMPTY_FLAG] = 1'b1;
  end

  // Outputs are registered: each is loaded on the edge that enters the state it belongs to.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    resp_d    = resp_q;
    rdata_d   = '0;
    ready_d   = 1'b0;
    read_en_d = 1'b0;
    clear_d   = 1'b0;
    irq_en_d  = irq_en_q;
    fs_clr    = 1'b0;
    case (state_q)
      S_IDLE: if (hit) begin
        if (is_data && !mem_we && KB_status) begin
          resp_d    = {57'b0, KB_data};
          read_en_d = 1'b1;
          state_d   = S_POP;
        end else begin
          state_d = S_RESP;
          ready_d = 1'b1;
          if (!mem_we) begin
            if (is_status)    rdata_d = status_val;
            else if (is_data) rdata_d = empty_val;
            else              rdata_d = ctrl_val;
          end else if (is_ctrl) begin
            clear_d  = mem_wdata[CTRL_CLEAR];
            irq_en_d = mem_wdata[CTRL_IRQ_EN];
            fs_clr   = mem_wdata[CTRL_FS_CLEAR];
          end
        end
      end
      S_POP: begin
        state_d = S_WAIT;
        cnt_d   = 4'(POP_WAIT - 1);
      end
      S_WAIT: if (cnt_q == 4'd0) begin
        state_d = S_RESP;
        ready_d = 1'b1;
        rdata_d = resp_q;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
    // A buf_full sample on the clearing edge keeps the sticky bit set.
    full_seen_d = buf_full | (full_seen_q & ~fs_clr);
    irq_d       = irq_en_q & KB_status;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      resp_q      <= '0;
      rdata_q     <= '0;
      ready_q     <= 1'b0;
      read_en_q   <= 1'b0;
      clear_q     <= 1'b0;
      irq_en_q    <= 1'b0;
      full_seen_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      resp_q      <= resp_d;
      rdata_q     <= rdata_d;
      ready_q     <= ready_d;
      read_en_q   <= read_en_d;
      clear_q     <= clear_d;
      irq_en_q    <= irq_en_d;
      full_seen_q <= full_seen_d;
      irq_q       <= irq_d;
    end
  end

  assign mem_rdata  = rdata_q;
  assign mem_ready  = ready_q;
  assign KB_read_en = read_en_q;
  assign KB_clear   = clear_q;
  assign kb_irq     = irq_q;

endmodule

// File: doc/kb_mmio_port.md
Name: kb_mmio_port

Overview:
- Memory-mapped bridge between the Y86 CPU data-memory bus and the keyboard interface (keyboard_interface_top).
- Consumes KB_status, KB_data and buf_full, and drives KB_read_en and KB_clear.
- Exposes STATUS, DATA and CONTROL registers, plus a level interrupt.
- Sits directly downstream of the keyboard interface, in the CPU memory decode path.

Parameters:
- KB_BASE_ADDR, 64'h0000_0000_0000_F000, byte address of STATUS; the block's 24-byte window starts here.
- POP_WAIT, 2, cycles to wait after a KB_read_en pulse before the block accepts the next request (keyboard buffer settle time); legal range 1-15.

Ports:
- clk  in  1  master clock.
- rst  in  1  synchronous, active-high reset.
- mem_req  in  1  bus request; held together with mem_addr, mem_we and mem_wdata until mem_ready.
- mem_we  in  1  1 = write, 0 = read.
- mem_addr  in  64  byte address.
- mem_wdata  in  64  write data.
- mem_rdata  out  64  read data; valid only while mem_ready=1, otherwise 0.
- mem_ready  out  1  one-cycle completion pulse.
- KB_status  in  1  keyboard buffer non-empty.
- KB_data  in  7  ASCII code at the buffer head.
- buf_full  in  1  keyboard buffer full.
- KB_read_en  out  1  one-cycle pop strobe.
- KB_clear  out  1  one-cycle buffer-clear strobe.
- kb_irq  out  1  registered interrupt: irq_en & KB_status.

Behaviour:
- Address decode:
  - hit = mem_req & (mem_addr >= BASE) & (mem_addr < BASE+24) & (mem_addr[2:0]==0).
  - Offsets: 0x0 STATUS, 0x8 DATA, 0x10 CONTROL.
  - Out-of-window or misaligned requests are ignored entirely: no mem_ready, no side effects.
- STATUS read value:
  - bit0 KB_status, bit1 buf_full, bit2 full_seen (sticky), bit3 irq_en; all other bits 0.
- Writes to STATUS or DATA are ignored, but still complete with mem_ready.
- CONTROL write:
  - bit0 = 1 → KB_clear pulse.
  - bit1 → loaded into irq_en.
  - bit2 = 1 → clears full_seen.
- CONTROL read returns {62'b0, irq_en, 1'b0}.
- full_seen is set on any cycle with buf_full=1. If the set and the clear coincide, set wins.
- FSM states: IDLE, POP, WAIT, RESP.
  - IDLE, hit and DATA read with KB_status=1: latch {57'b0, KB_data} into the response register and assert KB_read_en in the next cycle (POP). POP → WAIT.
  - WAIT: counter loads POP_WAIT-1 and decrements; at 0 → RESP.
  - RESP: mem_ready=1 for one cycle → IDLE.
  - DATA read with KB_status=0: returns 64'h8000_0000_0000_0000 (bit63 = empty flag) and does not pop. Path is IDLE → RESP.
  - STATUS or CONTROL access: IDLE → RESP. Latency is 1 cycle from accept to mem_ready.
  - CONTROL side effects (KB_clear pulse, irq_en update) happen in the RESP cycle.
  - DATA pop latency: mem_ready arrives POP_WAIT+2 cycles after accept.
- Requests arriving outside IDLE are not sampled. The requester holds mem_req, so the request is taken when the FSM returns to IDLE. There is at most one outstanding request.
- mem_req held high into the cycle after RESP is treated as a new request. A requester must drop mem_req after mem_ready.
- KB_read_en and KB_clear are never high in the same cycle; they come from distinct states and access types.
- kb_irq is registered, so it follows irq_en & KB_status with 1 cycle of delay.
- Reset, including mid-operation:
  - State goes to IDLE.
  - mem_ready=0, mem_rdata=0, KB_read_en=0, KB_clear=0, kb_irq=0, irq_en=0, full_seen=0, counter=0.
  - A pop already strobed is not undone, and the interrupted request gets no response.

Decomposition:
- Shared package kb_mmio_pkg holds:
  - offset constants KB_OFF_STATUS, KB_OFF_DATA and KB_OFF_CTRL;
  - STATUS and CONTROL bit-index constants;
  - the KB_EMPTY_FLAG bit position;
  - the FSM state enum.
- No sub-module: the decode, the FSM with counter, and the register file fit in one module.

Test Plan:
- STATUS read after reset with KB_status=1, buf_full=0 → mem_ready 1 cycle after accept; rdata=64'h1; KB_read_en never asserted.
- DATA read with KB_status=1, KB_data=7'h41, POP_WAIT=2:
  - KB_read_en high exactly 1 cycle, one cycle after accept;
  - mem_ready at accept+4;
  - rdata=64'h41.
- DATA read with KB_status=0 → rdata=64'h8000_0000_0000_0000 at accept+1; no KB_read_en.
- CONTROL write 64'h3 →
  - KB_clear one-cycle pulse;
  - irq_en=1;
  - with KB_status=1, kb_irq=1 one cycle later;
  - a following CONTROL write of 0 drops kb_irq one cycle after RESP.
- buf_full pulsed 1 cycle → STATUS bit2=1 persists. CONTROL write of 64'h4 clears it; if buf_full is high on the same cycle, bit2 stays 1.
- Reset asserted during WAIT → no mem_ready; all outputs 0 next cycle. Misaligned address BASE+4 and out-of-window address BASE+24 → no mem_ready within 10 cycles.
